// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_arb_pkg                                                  |
// | Purpose: shared types and constants for the memory-port arbiter:      |
// |          FSM state encoding, access-size codes, timeout default and   |
// |          the alignment/legality check for a request.                  |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  // Access size codes (number of bytes).
  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // Arbiter FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // High when the request must be answered with an error and never reaches
  // memory: unsupported size or an address not naturally aligned to it.
  function automatic logic req_illegal(input logic [2:0] size,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_arb_rr2                                                  |
// | Purpose: two-way round-robin arbiter with a one-bit priority pointer. |
// | Ports  : clk, rst_n     - clock, async active-low reset               |
// |          req_i[1:0]     - request lines (already qualified by caller) |
// |          accept_i       - grant is consumed this cycle; move pointer  |
// |          gnt_o[1:0]     - one-hot (or zero) grant, combinational      |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module mem_arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // prio_q names the port that wins a tie; reset favours port 1.
  logic prio_q;
  logic prio_d;

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // After a grant, the tie goes to the other port: granting port 0 leaves
  // prio=1, granting port 1 leaves prio=0.
  always_comb begin
    prio_d = prio_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : mem_arb_rr2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_port_arbiter                                             |
// | Purpose: shares one data-memory port between an instruction-fetch     |
// |          port (0) and a load/store port (1). One request in flight;   |
// |          IDLE -> ACCESS -> RESP, with misaligned/illegal requests      |
// |          answered from IDLE straight to RESP and a bounded wait for   |
// |          mem_ready.                                                   |
// | Ports  : clk, rst_n                 - clock, async active-low reset   |
// |          req0_*_i / req0_ready_o    - fetch request (word read)       |
// |          rsp0_*_o                   - fetch response                  |
// |          req1_*_i / req1_ready_o    - load/store request              |
// |          rsp1_*_o                   - load/store response             |
// |          mem_*_o / mem_*_i          - shared memory port              |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_addr_i,
  output logic        req0_ready_o,
  output logic        rsp0_valid_o,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_err_o,
  input  logic        req1_valid_i,
  input  logic        req1_we_i,
  input  logic [2:0]  req1_size_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        req1_ready_o,
  output logic        rsp1_valid_o,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic        winner_q, winner_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        w_idle;
  logic        w_access;
  logic        w_resp;
  logic [1:0]  w_gnt;
  logic        w_sel_we;
  logic [2:0]  w_sel_size;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_rsp_data;

  // Qualifying with rst_n keeps the ready outputs low while reset is held,
  // even though the grant itself is combinational from the valids.
  assign w_idle   = (state_q == ST_IDLE) && rst_n;
  assign w_access = (state_q == ST_ACCESS);
  assign w_resp   = (state_q == ST_RESP);

  mem_arb_rr2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_valid_i, req0_valid_i} & {2{w_idle}}),
    .accept_i (w_idle),
    .gnt_o    (w_gnt)
  );

  assign req0_ready_o = w_gnt[0];
  assign req1_ready_o = w_gnt[1];

  // Port 0 is always a word read.
  assign w_sel_we    = w_gnt[1] ? req1_we_i    : 1'b0;
  assign w_sel_size  = w_gnt[1] ? req1_size_i  : SZ_W;
  assign w_sel_addr  = w_gnt[1] ? req1_addr_i  : req0_addr_i;
  assign w_sel_wdata = w_gnt[1] ? req1_wdata_i : 32'd0;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt != 2'b00) begin
          winner_d = w_gnt[1];
          we_d     = w_sel_we;
          size_d   = w_sel_size;
          addr_d   = w_sel_addr;
          wdata_d  = w_sel_wdata;
          rdata_d  = 32'd0;
          err_d    = req_illegal(w_sel_size, w_sel_addr[1:0]);
          cnt_d    = 8'd1;
          state_d  = err_d ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A ready in the last allowed cycle still completes normally.
        if (mem_ready_i) begin
          rdata_d = mem_rdata_i;
          state_d = ST_RESP;
        end else if (cnt_q >= c_timeout) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory port is driven only while a request is in ACCESS.
  assign mem_req_o   = w_access;
  assign mem_we_o    = w_access & we_q;
  assign mem_size_o  = w_access ? size_q  : 3'd0;
  assign mem_addr_o  = w_access ? addr_q  : 32'd0;
  assign mem_wdata_o = w_access ? wdata_q : 32'd0;

  // Stores and errors return zero data.
  assign w_rsp_data = (we_q || err_q) ? 32'd0 : rdata_q;

  assign rsp0_valid_o = w_resp & ~winner_q;
  assign rsp1_valid_o = w_resp & winner_q;
  assign rsp0_data_o  = rsp0_valid_o ? w_rsp_data : 32'd0;
  assign rsp1_data_o  = rsp1_valid_o ? w_rsp_data : 32'd0;
  assign rsp0_err_o   = rsp0_valid_o & err_q;
  assign rsp1_err_o   = rsp1_valid_o & err_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mem_port_arbiter                                          |
// | Purpose: directed self-checking bench for mem_port_arbiter, built     |
// |          with MEM_TIMEOUT=4.                                          |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_addr;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_data;
  logic        rsp0_err;
  logic        req1_valid;
  logic        req1_we;
  logic [2:0]  req1_size;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_data;
  logic        rsp1_err;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  mem_port_arbiter #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_addr_i  (req0_addr),
    .req0_ready_o (req0_ready),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_data_o  (rsp0_data),
    .rsp0_err_o   (rsp0_err),
    .req1_valid_i (req1_valid),
    .req1_we_i    (req1_we),
    .req1_size_i  (req1_size),
    .req1_addr_i  (req1_addr),
    .req1_wdata_i (req1_wdata),
    .req1_ready_o (req1_ready),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_data_o  (rsp1_data),
    .rsp1_err_o   (rsp1_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_size_o   (mem_size),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ready_i  (mem_ready),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Single-port request on port 1 rejected without memory access.
  task automatic p1_illegal(input string tag, input logic [2:0] size, input logic [31:0] addr);
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = size; req1_addr = addr;
    #1;
    chk({tag, "_ready"}, {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    chk({tag, "_memreq"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, rsp1_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, rsp1_err}, 32'd1);
    chk({tag, "_data"}, rsp1_data, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, rsp1_valid}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 32'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = 3'd4;
    req1_addr = 32'h100; req1_wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;

    // Reset state: outputs all zero even with a valid request pending.
    tick(); tick();
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    // Single LW on port 1, ready in first ACCESS cycle: two-cycle latency.
    #1;
    chk("lw_ready1", {31'd0, req1_ready}, 32'd1);
    chk("lw_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    req1_valid = 1'b0;
    chk("lw_memreq", {31'd0, mem_req}, 32'd1);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_size", {29'd0, mem_size}, 32'd4);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    chk("lw_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("lw_rsp_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("lw_rsp_data", rsp1_data, 32'hDEADBEEF);
    chk("lw_rsp_err", {31'd0, rsp1_err}, 32'd0);
    chk("lw_rsp0", {31'd0, rsp0_valid}, 32'd0);
    chk("lw_memreq_off", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lw_rsp_once", {31'd0, rsp1_valid}, 32'd0);

    // Fresh reset, then both ports valid for four grants: order 1,0,1,0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h200;
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = 3'd4; req1_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'hA5A50000;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic exp1;
      exp1 = (k % 2 == 0);
      chk($sformatf("rr%0d_ready1", k), {31'd0, req1_ready}, {31'd0, exp1});
      chk($sformatf("rr%0d_ready0", k), {31'd0, req0_ready}, {31'd0, ~exp1});
      tick();
      chk($sformatf("rr%0d_acc_ready", k), {30'd0, req1_ready, req0_ready}, 32'd0);
      chk($sformatf("rr%0d_addr", k), mem_addr, exp1 ? 32'h300 : 32'h200);
      tick();
      chk($sformatf("rr%0d_resp_ready", k), {30'd0, req1_ready, req0_ready}, 32'd0);
      chk($sformatf("rr%0d_rsp", k), {30'd0, rsp1_valid, rsp0_valid}, exp1 ? 32'd2 : 32'd1);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    tick();

    // Illegal requests: misaligned half, bad size.
    p1_illegal("sh_mis", 3'd2, 32'h101);
    p1_illegal("size3", 3'd3, 32'h100);

    // Misaligned fetch on port 0.
    req0_valid = 1'b1; req0_addr = 32'h202;
    #1;
    chk("if_mis_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("if_mis_memreq", {31'd0, mem_req}, 32'd0);
    chk("if_mis_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    chk("if_mis_err", {31'd0, rsp0_err}, 32'd1);
    tick();

    // Timeout: mem_ready held low, mem_req high exactly four cycles.
    req0_valid = 1'b1; req0_addr = 32'h400;
    tick();
    req0_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_memreq%0d", c), {31'd0, mem_req}, 32'd1);
      tick();
    end
    chk("to_memreq_off", {31'd0, mem_req}, 32'd0);
    chk("to_rsp0", {31'd0, rsp0_valid}, 32'd1);
    chk("to_err", {31'd0, rsp0_err}, 32'd1);
    chk("to_data", rsp0_data, 32'd0);
    tick();

    // Reset asserted mid-ACCESS after a port-1 grant.
    req1_valid = 1'b1; req1_we = 1'b0; req1_size = 3'd4; req1_addr = 32'h500;
    tick();
    req1_valid = 1'b0;
    chk("rm_memreq", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_memreq_async", {31'd0, mem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rm_norsp%0d", c), {29'd0, rsp1_valid, rsp0_valid, mem_req}, 32'd0);
      tick();
    end
    req0_valid = 1'b1; req0_addr = 32'h600;
    req1_valid = 1'b1; req1_addr = 32'h700;
    #1;
    chk("rm_grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ready = 1'b0;
    chk("rm_rsp1_data", rsp1_data, 32'h0BADF00D);
    tick();

    // SB store, mem_ready in the fourth ACCESS cycle; fields held stable.
    req1_valid = 1'b1; req1_we = 1'b1; req1_size = 3'd1;
    req1_addr = 32'h803; req1_wdata = 32'h12345678;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    req1_valid = 1'b0; req1_we = 1'b0; req1_wdata = 32'd0; req1_addr = 32'd0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("sb_req%0d", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("sb_we%0d", c), {31'd0, mem_we}, 32'd1);
      chk($sformatf("sb_size%0d", c), {29'd0, mem_size}, 32'd1);
      chk($sformatf("sb_addr%0d", c), mem_addr, 32'h803);
      chk($sformatf("sb_wdata%0d", c), mem_wdata, 32'h12345678);
      if (c == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    chk("sb_rsp_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("sb_rsp_data", rsp1_data, 32'd0);
    chk("sb_rsp_err", {31'd0, rsp1_err}, 32'd0);
    chk("sb_we_off", {31'd0, mem_we}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 255, max ACCESS cycles waiting for mem_ready before error response (legal range 1..255).
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid in 1, req0_addr in 32 (instruction-fetch word read request).
REQ-005 SHALL have ports: req0_ready out 1 (request accepted), rsp0_valid out 1, rsp0_data out 32, rsp0_err out 1.
REQ-006 SHALL have ports: req1_valid in 1, req1_we in 1 (1=store), req1_size in 3 (1/2/4 bytes), req1_addr in 32, req1_wdata in 32 (load/store request).
REQ-007 SHALL have ports: req1_ready out 1, rsp1_valid out 1, rsp1_data out 32, rsp1_err out 1.
REQ-008 SHALL have ports: mem_req out 1, mem_we out 1, mem_size out 3, mem_addr out 32, mem_wdata out 32, mem_ready in 1, mem_rdata in 32 (shared data-memory port).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-010 SHALL, in IDLE with any reqN_valid, select one winner, assert its reqN_ready combinationally that cycle, latch its fields, and enter ACCESS (or RESP on error per REQ-015/016) next cycle.
REQ-011 SHALL arbitrate round-robin: on simultaneous valid, grant the port not granted last; pointer after reset favours port 1.
REQ-012 SHALL keep reqN_ready low in ACCESS and RESP; at most one reqN_ready high per cycle.
REQ-013 SHALL, in ACCESS, drive mem_req=1 with latched we/size/addr/wdata held stable until the cycle mem_ready=1, capture mem_rdata that cycle, then enter RESP.
REQ-014 SHALL drive mem_req=0, mem_we=0, mem_size/addr/wdata=0 outside ACCESS.
REQ-015 SHALL treat port 0 as size 4, we 0; port 0 with addr[1:0]!=0 gives error without memory access.
REQ-016 SHALL give error without memory access for port 1 when size not in {1,2,4}, size 2 with addr[0]=1, or size 4 with addr[1:0]!=0.
REQ-017 SHALL count ACCESS cycles from 1; if mem_ready not seen by cycle MEM_TIMEOUT, drop mem_req and enter RESP with error.
REQ-018 SHALL, in RESP, pulse rsp{winner}_valid for exactly one cycle with data = captured mem_rdata (loads/fetches), 0 for stores and errors; rspN_err=1 only on error; then return to IDLE.
REQ-019 SHALL pass data unmodified; sign/zero extension and lane alignment belong to the load/store unit.
REQ-020 SHALL give minimum latency request-accept to rsp_valid of 2 cycles (mem_ready in first ACCESS cycle); throughput one request per 3 cycles max.
REQ-021 SHALL ignore mem_ready outside ACCESS.

Reset
REQ-022 SHALL on rst_n=0 immediately force state IDLE, RR pointer to port 1, timeout counter 0, and all outputs 0, including mid-ACCESS (mem_req drops asynchronously).
REQ-023 SHALL discard any in-flight request on reset; no response issued after rst_n release.

Structure
REQ-024 SHALL place state enum, size constants (SZ_B=1, SZ_H=2, SZ_W=4) and MEM_TIMEOUT default in shared package mem_arb_pkg.
REQ-025 SHALL use one sub-module mem_arb_rr2 (2-way round-robin arbiter with pointer register).

Verification
REQ-026 SHALL test: single port1 LW addr 0x100, mem_ready 1st ACCESS cycle, rdata 0xDEADBEEF -> rsp1_valid one cycle, rsp1_data 0xDEADBEEF, 2-cycle latency.
REQ-027 SHALL test: both valid continuously for 4 grants after reset -> grant order 1,0,1,0; never both ready.
REQ-028 SHALL test: port1 SH addr 0x101 -> no mem_req, rsp1_err=1, rsp1_data 0; port1 size 3 -> same.
REQ-029 SHALL test: MEM_TIMEOUT=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then rsp err=1.
REQ-030 SHALL test: rst_n low during ACCESS -> mem_req 0 same cycle, no rsp after release, next grant goes to port 1.
REQ-031 SHALL test: port1 SB wdata 0x12345678, mem_ready after 3 cycles -> mem_we/size/addr/wdata stable throughout, rsp1_data 0.
